// File: rtl/wishbone_master_param.sv
// Single-outstanding Wishbone master bridging a stalling core port to NUM_SLV
// slave channels selected by an address field, with per-access timeout.
module wishbone_master_param #(
  parameter int NUM_SLV     = 3,
  parameter int SEL_LSB     = 16,
  parameter int SEL_W       = 2,
  parameter int ADR_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [31:0]            vy_adres_i,
  input  logic [31:0]            vy_veri_i,
  input  logic [3:0]             vy_veri_maske_i,
  input  logic                   vy_sec_i,
  output logic [31:0]            vy_veri_o,
  output logic                   vy_durdur_o,
  output logic                   vy_hata_o,
  output logic [ADR_W-1:0]       adr_o,
  output logic [31:0]            dat_o,
  output logic                   we_o,
  output logic [3:0]             sel_o,
  output logic                   stb_o,
  output logic [NUM_SLV-1:0]     cyc_o,
  input  logic [NUM_SLV-1:0]     ack_i,
  input  logic [NUM_SLV-1:0]     err_i,
  input  logic [32*NUM_SLV-1:0]  dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [SEL_W:0] NUM_SLV_W = (SEL_W + 1)'(NUM_SLV);

  function automatic logic [NUM_SLV-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_SLV-1:0] v;
    for (int k = 0; k < NUM_SLV; k++) begin
      v[k] = (idx == SEL_W'(k));
    end
    return v;
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [SEL_W-1:0]   idx_r;
  logic [SEL_W-1:0]   idx_nxt_s;
  logic [SEL_W-1:0]   idx_req_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               mapped_s;
  logic [NUM_SLV-1:0] sel_oh_s;
  logic               ack_sel_s;
  logic               err_sel_s;
  logic [31:0]        rdat_sel_s;
  logic               timeout_s;
  logic               done_s;
  logic               fail_s;
  logic               unused_s;

  assign idx_req_s = vy_adres_i[SEL_LSB+SEL_W-1:SEL_LSB];
  assign mapped_s  = ({1'b0, idx_req_s} < NUM_SLV_W);
  assign sel_oh_s  = onehot(idx_r);
  assign ack_sel_s = |(ack_i & sel_oh_s);
  assign err_sel_s = |(err_i & sel_oh_s);
  assign timeout_s = (TIMEOUT_CYC != 0) && (cnt_r == TO_LAST);
  assign unused_s  = ^vy_adres_i;

  // AND-OR read-data mux over the selected slave slice
  always_comb begin
    rdat_sel_s = 32'd0;
    for (int k = 0; k < NUM_SLV; k++) begin
      rdat_sel_s = rdat_sel_s | (dat_i[32*k +: 32] & {32{sel_oh_s[k]}});
    end
  end

  // Next-state, completion decode and core stall
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    done_s      = 1'b0;
    fail_s      = 1'b0;
    vy_durdur_o = 1'b0;
    case (state_r)
      IDLE: begin
        if (vy_sec_i) begin
          vy_durdur_o = 1'b1;
          idx_nxt_s   = idx_req_s;
          if (mapped_s) begin
            state_nxt_s = BUS;
          end else begin
            state_nxt_s = RESP;
            done_s      = 1'b1;
            fail_s      = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUS: begin
        vy_durdur_o = 1'b1;
        // error takes precedence over a simultaneous ack
        if (err_sel_s) begin
          state_nxt_s = RESP;
          done_s      = 1'b1;
          fail_s      = 1'b1;
        end else if (ack_sel_s) begin
          state_nxt_s = RESP;
          done_s      = 1'b1;
        end else if (timeout_s) begin
          state_nxt_s = RESP;
          done_s      = 1'b1;
          fail_s      = 1'b1;
        end else begin
          state_nxt_s = BUS;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request capture; only updated in IDLE so the bus fields stay stable in BUS
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adr_o <= {ADR_W{1'b0}};
      dat_o <= 32'd0;
      sel_o <= 4'd0;
      we_o  <= 1'b0;
      idx_r <= {SEL_W{1'b0}};
    end else if (state_r == IDLE && vy_sec_i) begin
      adr_o <= vy_adres_i[ADR_W-1:0];
      dat_o <= vy_veri_i;
      sel_o <= vy_veri_maske_i;
      we_o  <= |vy_veri_maske_i;
      idx_r <= idx_req_s;
    end
  end

  // Registered cycle/strobe, asserted for exactly the cycles spent in BUS
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_o <= {NUM_SLV{1'b0}};
      stb_o <= 1'b0;
    end else if (state_nxt_s == BUS) begin
      cyc_o <= onehot(idx_nxt_s);
      stb_o <= 1'b1;
    end else begin
      cyc_o <= {NUM_SLV{1'b0}};
      stb_o <= 1'b0;
    end
  end

  // Timeout counter: zero outside BUS, counts BUS cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == BUS && TIMEOUT_CYC != 0) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Completion result, held until the next completion
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vy_veri_o <= 32'd0;
      vy_hata_o <= 1'b0;
    end else if (done_s) begin
      vy_hata_o <= fail_s;
      vy_veri_o <= fail_s ? 32'd0 : rdat_sel_s;
    end
  end

endmodule

// File: tb/tb_wishbone_master_param.sv
// Directed bench for wishbone_master_param: read, write, timeout, unmapped,
// back-to-back, error-over-ack and asynchronous reset mid-access.
module tb_wishbone_master_param;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] vy_adres_i = 32'd0;
  logic [31:0] vy_veri_i = 32'd0;
  logic [3:0]  vy_veri_maske_i = 4'd0;
  logic        vy_sec_i = 1'b0;
  logic [31:0] vy_veri_o;
  logic        vy_durdur_o;
  logic        vy_hata_o;
  logic [7:0]  adr_o;
  logic [31:0] dat_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        stb_o;
  logic [2:0]  cyc_o;
  logic [2:0]  ack_i = 3'd0;
  logic [2:0]  err_i = 3'd0;
  logic [95:0] dat_i = 96'd0;

  int errors = 0;
  int checks = 0;
  int cyc_cnt;

  wishbone_master_param #(
    .NUM_SLV(3), .SEL_LSB(16), .SEL_W(2), .ADR_W(8), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .vy_adres_i(vy_adres_i), .vy_veri_i(vy_veri_i),
    .vy_veri_maske_i(vy_veri_maske_i), .vy_sec_i(vy_sec_i),
    .vy_veri_o(vy_veri_o), .vy_durdur_o(vy_durdur_o), .vy_hata_o(vy_hata_o),
    .adr_o(adr_o), .dat_o(dat_o), .we_o(we_o), .sel_o(sel_o),
    .stb_o(stb_o), .cyc_o(cyc_o),
    .ack_i(ack_i), .err_i(err_i), .dat_i(dat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #3;
    chk("rst_cyc", {29'd0, cyc_o}, 32'd0);
    chk("rst_stb", {31'd0, stb_o}, 32'd0);
    chk("rst_we", {31'd0, we_o}, 32'd0);
    chk("rst_sel", {28'd0, sel_o}, 32'd0);
    chk("rst_adr", {24'd0, adr_o}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_veri", vy_veri_o, 32'd0);
    chk("rst_hata", {31'd0, vy_hata_o}, 32'd0);
    #9 rst_ni = 1'b1;
    step();

    // read from slave 1, ack on second BUS cycle
    vy_adres_i = 32'h2001_0004; vy_veri_maske_i = 4'h0; vy_sec_i = 1'b1;
    #1 chk("rd_stall_idle", {31'd0, vy_durdur_o}, 32'd1);
    step();
    vy_sec_i = 1'b0;
    chk("rd_cyc", {29'd0, cyc_o}, 32'h2);
    chk("rd_stb", {31'd0, stb_o}, 32'd1);
    chk("rd_adr", {24'd0, adr_o}, 32'h04);
    chk("rd_we", {31'd0, we_o}, 32'd0);
    ack_i = 3'b001; err_i = 3'b100;
    step();
    chk("rd_ignore_other", {29'd0, cyc_o}, 32'h2);
    chk("rd_stall_bus", {31'd0, vy_durdur_o}, 32'd1);
    ack_i = 3'b010; err_i = 3'b000; dat_i = {32'h0, 32'hA5A5_0001, 32'h0};
    step();
    ack_i = 3'b000;
    chk("rd_resp_stall", {31'd0, vy_durdur_o}, 32'd0);
    chk("rd_resp_cyc", {29'd0, cyc_o}, 32'd0);
    chk("rd_resp_stb", {31'd0, stb_o}, 32'd0);
    chk("rd_veri", vy_veri_o, 32'hA5A5_0001);
    chk("rd_hata", {31'd0, vy_hata_o}, 32'd0);
    step();
    chk("rd_hold_veri", vy_veri_o, 32'hA5A5_0001);
    chk("idle_stall", {31'd0, vy_durdur_o}, 32'd0);

    // write to slave 2
    vy_adres_i = 32'h2002_0008; vy_veri_maske_i = 4'hF; vy_veri_i = 32'h0000_1234; vy_sec_i = 1'b1;
    step();
    vy_sec_i = 1'b0;
    chk("wr_cyc", {29'd0, cyc_o}, 32'h4);
    chk("wr_we", {31'd0, we_o}, 32'd1);
    chk("wr_sel", {28'd0, sel_o}, 32'hF);
    chk("wr_dat", dat_o, 32'h0000_1234);
    chk("wr_adr", {24'd0, adr_o}, 32'h08);
    ack_i = 3'b100; dat_i = {32'hDEAD_0002, 32'h0, 32'h0};
    step();
    ack_i = 3'b000;
    chk("wr_hata", {31'd0, vy_hata_o}, 32'd0);
    chk("wr_veri", vy_veri_o, 32'hDEAD_0002);
    step();

    // timeout on slave 1
    vy_adres_i = 32'h2001_0010; vy_veri_maske_i = 4'h0; vy_sec_i = 1'b1;
    step();
    vy_sec_i = 1'b0;
    cyc_cnt = 0;
    while (cyc_o != 3'd0 && cyc_cnt < 40) begin
      cyc_cnt++;
      step();
    end
    chk("to_cyc_len", cyc_cnt, 32'd16);
    chk("to_hata", {31'd0, vy_hata_o}, 32'd1);
    chk("to_veri", vy_veri_o, 32'd0);
    chk("to_stall", {31'd0, vy_durdur_o}, 32'd0);
    step();

    // successful read from slave 0 to clear the error flag
    vy_adres_i = 32'h2000_0020; vy_sec_i = 1'b1;
    step();
    vy_sec_i = 1'b0;
    chk("s0_cyc", {29'd0, cyc_o}, 32'h1);
    ack_i = 3'b001; dat_i = {32'h0, 32'h0, 32'h1111_0000};
    step();
    ack_i = 3'b000;
    chk("s0_hata", {31'd0, vy_hata_o}, 32'd0);
    chk("s0_veri", vy_veri_o, 32'h1111_0000);
    step();

    // unmapped, issued in the first IDLE cycle after RESP
    vy_adres_i = 32'h2003_0000; vy_sec_i = 1'b1;
    #1 chk("um_stall_idle", {31'd0, vy_durdur_o}, 32'd1);
    step();
    vy_sec_i = 1'b0;
    chk("um_cyc", {29'd0, cyc_o}, 32'd0);
    chk("um_stall", {31'd0, vy_durdur_o}, 32'd0);
    chk("um_hata", {31'd0, vy_hata_o}, 32'd1);
    chk("um_veri", vy_veri_o, 32'd0);
    step();

    // simultaneous ack and err on slave 0: error wins
    vy_adres_i = 32'h2000_0000; vy_sec_i = 1'b1;
    step();
    vy_sec_i = 1'b0;
    chk("ae_cyc", {29'd0, cyc_o}, 32'h1);
    ack_i = 3'b001; err_i = 3'b001; dat_i = {32'h0, 32'h0, 32'h1234_5678};
    step();
    ack_i = 3'b000; err_i = 3'b000;
    chk("ae_hata", {31'd0, vy_hata_o}, 32'd1);
    chk("ae_veri", vy_veri_o, 32'd0);
    step();

    // asynchronous reset in the middle of a BUS cycle
    vy_adres_i = 32'h2002_0001; vy_veri_maske_i = 4'h3; vy_sec_i = 1'b1;
    step();
    vy_sec_i = 1'b0;
    chk("ar_cyc_pre", {29'd0, cyc_o}, 32'h4);
    chk("ar_stb_pre", {31'd0, stb_o}, 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("ar_cyc", {29'd0, cyc_o}, 32'd0);
    chk("ar_stb", {31'd0, stb_o}, 32'd0);
    chk("ar_we", {31'd0, we_o}, 32'd0);
    chk("ar_hata", {31'd0, vy_hata_o}, 32'd0);
    #2 rst_ni = 1'b1;
    step();
    chk("ar_idle_stall", {31'd0, vy_durdur_o}, 32'd0);
    chk("ar_idle_cyc", {29'd0, cyc_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wishbone_master_param.md
WISHBONE_MASTER_PARAM -- requirements
Module: wishbone_master_param

Interface
REQ-001 SHALL have parameter NUM_SLV, default 3, number of Wishbone slave channels (1..8).
REQ-002 SHALL have parameter SEL_LSB, default 16, LSB of the slave-index field in vy_adres_i.
REQ-003 SHALL have parameter SEL_W, default 2, width of the slave-index field (2^SEL_W >= NUM_SLV).
REQ-004 SHALL have parameter ADR_W, default 8, width of adr_o, taken from vy_adres_i[ADR_W-1:0].
REQ-005 SHALL have parameter TIMEOUT_CYC, default 255, BUS cycles without ack/err before abort; 0 disables timeout.
REQ-006 SHALL have ports, in this order:
clk_i  in  1  single clock, rising edge
rst_ni  in  1  asynchronous, active-low reset
vy_adres_i  in  32  core address
vy_veri_i  in  32  core write data
vy_veri_maske_i  in  4  byte mask; nonzero = write
vy_sec_i  in  1  core request
vy_veri_o  out  32  registered read data
vy_durdur_o  out  1  core stall
vy_hata_o  out  1  registered bus error flag for the completing access
adr_o  out  ADR_W  latched address
dat_o  out  32  latched write data
we_o  out  1  latched write enable
sel_o  out  4  latched byte select
stb_o  out  1  strobe
cyc_o  out  NUM_SLV  one-hot cycle per slave
ack_i  in  NUM_SLV  per-slave ack
err_i  in  NUM_SLV  per-slave error
dat_i  in  32*NUM_SLV  per-slave read data, slave k at [32k+31:32k]

Function
REQ-007 SHALL implement FSM states IDLE, BUS, RESP.
REQ-008 In IDLE with vy_sec_i=1 SHALL latch address, data, mask and index idx=vy_adres_i[SEL_LSB+SEL_W-1:SEL_LSB] on the clock edge.
REQ-009 IDLE -> BUS if idx < NUM_SLV; IDLE -> RESP with error if idx >= NUM_SLV (unmapped, no cyc/stb issued).
REQ-010 In BUS SHALL drive stb_o=1 and cyc_o[idx]=1, all other cyc_o bits 0; adr_o/dat_o/we_o/sel_o stable for the whole BUS state.
REQ-011 we_o SHALL equal OR of latched mask; sel_o SHALL equal latched mask.
REQ-012 In BUS, err_i[idx]=1 -> RESP, vy_hata_o<=1, vy_veri_o<=0; err_i and ack_i in the same cycle: error wins.
REQ-013 In BUS, ack_i[idx]=1 with err_i[idx]=0 -> RESP, vy_veri_o<=dat_i slice idx (reads and writes), vy_hata_o<=0.
REQ-014 ack_i/err_i bits of non-selected slaves SHALL be ignored.
REQ-015 Timeout counter SHALL clear on BUS entry, increment each BUS cycle; on reaching TIMEOUT_CYC without ack/err -> RESP, vy_hata_o<=1, vy_veri_o<=0, cyc/stb dropped.
REQ-016 RESP SHALL last exactly one cycle, stb_o=0, cyc_o=0, then -> IDLE unconditionally.
REQ-017 vy_durdur_o SHALL be 1 in IDLE when vy_sec_i=1, 1 throughout BUS, 0 in RESP and in IDLE when vy_sec_i=0.
REQ-018 vy_veri_o and vy_hata_o SHALL hold their value until the next completion.
REQ-019 Latency: mapped access with ack in first BUS cycle completes (durdur low) in cycle 2 after request; unmapped completes in cycle 1.
REQ-020 Back-to-back: a request present in the IDLE cycle following RESP SHALL start a new access with no extra idle cycle.

Reset
REQ-021 rst_ni=0 SHALL asynchronously force state IDLE, stb_o=0, cyc_o=0, we_o=0, sel_o=0, adr_o=0, dat_o=0, vy_veri_o=0, vy_hata_o=0, timeout counter 0.
REQ-022 Reset asserted mid-BUS SHALL drop cyc_o/stb_o immediately, without waiting for a clock; no completion reported.

Verification
REQ-023 Read: vy_adres_i=0x20010004, mask 0, ack_i[1] after 2 BUS cycles, dat_i slice1=0xA5A50001 -> cyc_o=3'b010, adr_o=0x04, we_o=0, vy_veri_o=0xA5A50001, vy_hata_o=0.
REQ-024 Write: vy_adres_i=0x20020008, mask 0xF, data 0x00001234, ack_i[2] -> cyc_o=3'b100, we_o=1, sel_o=0xF, dat_o=0x00001234, vy_hata_o=0.
REQ-025 Unmapped: NUM_SLV=3, vy_adres_i=0x20030000 -> cyc_o never nonzero, vy_durdur_o low in cycle 1, vy_hata_o=1, vy_veri_o=0.
REQ-026 Timeout: TIMEOUT_CYC=16, no ack -> cyc_o high exactly 16 cycles, then RESP with vy_hata_o=1.
REQ-027 ack_i[0] and err_i[0] together -> vy_hata_o=1, vy_veri_o=0; separately, rst_ni low mid-BUS -> cyc_o=0 before next clock edge.
